// File: rtl/aes_inv_iter.sv
// aes_inv_iter: iterative AES inverse cipher, one inverse round per clock.
// Ports: clk, rst_n, en; in: valid_i/ready_o/ciphertext_i/round_key_i; out: valid_o/ready_i/plaintext_o.
module aes_inv_iter #(
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] ciphertext_i,
  input  logic [127:0] round_key_i [Nr:0],
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] plaintext_o
);

  localparam int RW = (Nr > 1) ? $clog2(Nr) : 1;

  localparam logic [2047:0] ISB = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t          fsm, fsm_nx;
  logic [127:0]  state, state_nx;
  logic [RW-1:0] rnd, rnd_nx;
  logic [127:0]  last;

  function automatic logic [7:0] inv_s_box(input logic [7:0] b);
    return ISB[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv_s_box(s[8*i +: 8]);
    return o;
  endfunction

  // byte 4c+r sits at row r, column c; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b,
                                     input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 4'he) ^
                                gmul(a[(r+1)%4], 4'hb) ^
                                gmul(a[(r+2)%4], 4'hd) ^
                                gmul(a[(r+3)%4], 4'h9);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    return s ^ k;
  endfunction

  // shared by middle and final rounds; middle rounds add InvMixColumns
  assign last = add_round_key(inv_sub_bytes(inv_shift_rows(state)),
                              round_key_i[rnd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      state <= '0;
      rnd   <= '0;
    end else begin
      fsm   <= fsm_nx;
      state <= state_nx;
      rnd   <= rnd_nx;
    end
  end

  always_comb begin
    fsm_nx   = fsm;
    state_nx = state;
    rnd_nx   = rnd;
    if (en) begin
      unique case (fsm)
        IDLE: begin
          if (valid_i) begin
            state_nx = add_round_key(ciphertext_i, round_key_i[Nr]);
            rnd_nx   = RW'(Nr - 1);
            fsm_nx   = ROUND;
          end
        end
        ROUND: begin
          if (rnd != '0) begin
            state_nx = inv_mix_columns(last);
            rnd_nx   = rnd - RW'(1);
          end else begin
            state_nx = last;
            fsm_nx   = DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            if (valid_i) begin
              state_nx = add_round_key(ciphertext_i, round_key_i[Nr]);
              rnd_nx   = RW'(Nr - 1);
              fsm_nx   = ROUND;
            end else begin
              fsm_nx = IDLE;
            end
          end
        end
        default: fsm_nx = IDLE;
      endcase
    end
  end

  // ready_i feeds ready_o combinationally so DONE can reload back-to-back
  always_comb begin
    ready_o     = (fsm == IDLE) | ((fsm == DONE) & ready_i);
    valid_o     = (fsm == DONE);
    plaintext_o = (fsm == DONE) ? state : '0;
  end

endmodule

// File: doc/aes_inv_iter.md
# aes_inv_iter

Iterative AES inverse cipher that recovers plaintext from ciphertext one round per clock. It is the decrypt-side companion of the unrolled `aes` encryption pipeline and takes the same `round_key_i [Nr:0]` encryption key-schedule array, applying the keys in reverse order. It trades throughput for area: one shared inverse-round datapath, a round counter, and a valid/ready handshake on both sides.

## Interface
- `Nr`, from `define.svh` (10 for AES-128): number of rounds. Sets the round-key array bound and the latency.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: global advance enable. When 0, all registers hold and no handshake completes.
- `valid_i`  in  1: `ciphertext_i` is offered.
- `ready_o`  out  1: block can accept input.
- `ciphertext_i`  in  128: input block; byte 0 is `[127:120]`, column-major per FIPS-197.
- `round_key_i`  in  128 x (Nr+1): encryption round keys; index 0 is the cipher key.
- `valid_o`  out  1: `plaintext_o` is valid.
- `ready_i`  in  1: downstream accepts the output.
- `plaintext_o`  out  128: result block; same byte order as the input.

## Operation
- FSM states: IDLE, ROUND, DONE. Registers: 128-bit `state`, round counter `rnd` of $clog2(Nr) bits, and the FSM state.
- **Input transfer:** `valid_i & ready_o & en`.
  - Loads `state <= ciphertext_i ^ round_key_i[Nr]`.
  - Loads `rnd <= Nr-1`.
  - FSM moves to ROUND.
- **ROUND, en=1, `rnd > 0`:** one middle round per cycle.
  - `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key_i[rnd])`.
  - `rnd <= rnd-1`.
- **ROUND, en=1, `rnd == 0`:** final round, with no InvMixColumns.
  - `state <= InvSubBytes(InvShiftRows(state)) ^ round_key_i[0]`.
  - FSM moves to DONE.
- **DONE:**
  - `valid_o = 1` and `plaintext_o = state`.
  - Output transfer is `valid_o & ready_i & en`.
- **Leaving DONE:**
  - On an output transfer with no new input: go to IDLE.
  - On an output transfer with a simultaneous input transfer: load the new block and go to ROUND.
- **ready_o:** `(FSM==IDLE) | (FSM==DONE & ready_i)`. This is a combinational `ready_i`-to-`ready_o` path, allowed so that back-to-back operation works.
- **ROUND is non-interruptible:** `valid_i` is ignored and `ready_o = 0`.
- **Round keys:** `round_key_i` must be held stable from the input transfer until the output transfer. The block does not register the keys.
- **Datapath submodules:**
  - `inv_shift_rows`: row r rotated right by r bytes.
  - `inv_sub_bytes` and `inv_s_box`: 256-entry inverse S-box.
  - `inv_mix_columns`: GF(2^8) multiply by 0e/0b/0d/09 with reduction polynomial 0x11b.
  - XOR uses the existing `add_round_key`.

## Timing
- **Reset, asynchronous:**
  - FSM = IDLE, `state` = 0, `rnd` = 0.
  - `valid_o = 0`, `plaintext_o = 0`, `ready_o = 1`.
- **Reset mid-operation:** any in-flight block is discarded. The next transfer after reset release behaves as from a cold start.
- **Latency:** input transfer at cycle T gives `valid_o = 1` at cycle T+Nr+1 (T+11 for AES-128), assuming `en` is continuously 1.
  - Each cycle with `en = 0` during ROUND adds one cycle to the latency.
- **Throughput:** with `ready_i` held at 1, one block per Nr+1 cycles. The new input is accepted in the same cycle as the previous output transfer.
- **Backpressure:** while in DONE with `ready_i = 0`, `valid_o` and `plaintext_o` hold, and `ready_o = 0`.
- **en=0 in any state:** no register changes and no transfer on either port. `valid_o` and `plaintext_o` keep their values.

## Test plan
1. **FIPS-197 C.1:** `ciphertext_i = 69c4e0d86a7b0430d8cdb78070b4c55a`, keys expanded from `000102030405060708090a0b0c0d0e0f`, accepted at cycle T -> `valid_o` rises at T+11 with `plaintext_o = 00112233445566778899aabbccddeeff`.
2. **FIPS-197 Appendix B, with backpressure:** ciphertext `3925841d02dc09fbdc118597196a0b32`, key `2b7e151628aed2a6abf7158809cf4f3c`, `ready_i = 0` for 5 cycles after `valid_o` -> `plaintext_o = 3243f6a8885a308d313198a2e0370734` held stable, `ready_o = 0`, and a concurrent `valid_i` is not accepted.
3. **Back-to-back:** two vectors (C.1, then B), `valid_i` held at 1, `ready_i = 1` -> second accepted in the cycle of the first output transfer; outputs in order, 11 cycles apart.
4. **en stall:** drop `en` for 3 cycles while `rnd = 5` -> `valid_o` at T+14, correct plaintext, no state change during the stall.
5. **Reset mid-ROUND:** assert `rst_n` low at T+6 -> `valid_o = 0` and `ready_o = 1` immediately; the following C.1 run completes correctly at T'+11.
6. **Round trip:** 1000 random plaintexts and keys through `aes`, then through this block with the same keys -> output equals the original plaintext every time.
